// File: rtl/dm_responder.sv
// Data-memory responder: accepts one word/byte request, services it after WAIT_CYCLES wait states, then pulses ready.
// Optional macro DM_MISALIGN_CHECK_EN rejects word accesses with addr[1:0] != 0 and flags them on misalign.
module dm_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        bac_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign,
    output logic        busy
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BADDR_W = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 cap_we, cap_we_n;
    logic                 cap_bac, cap_bac_n;
    logic [BADDR_W-1:0]   cap_addr, cap_addr_n;
    logic [WORD_W-1:0]    cap_wdata, cap_wdata_n;
    logic [WORD_W-1:0]    rdata_n;
    logic                 ready_n;
    logic                 misalign_n;
    logic                 busy_n;

    logic [WORD_W-1:0]    mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [4:0]            lane_bit;
    logic [WORD_W-1:0]     rd_word;
    logic [7:0]            rd_byte;
    logic [WORD_W-1:0]     wr_word;
    logic                  wr_en;
    logic                  reject;

    // Address bits above the memory span alias onto it and are never looked at.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:BADDR_W];

    // Access datapath, driven purely by the frozen request fields.
    always_comb begin
        idx      = cap_addr[BADDR_W-1:2];
        lane     = cap_addr[1:0];
        lane_bit = {lane, 3'b000};
        rd_word  = mem[idx];
        rd_byte  = 8'(rd_word >> lane_bit);
        wr_word  = rd_word;
        if (cap_bac) begin
            wr_word[lane_bit +: 8] = cap_wdata[7:0];
        end else begin
            wr_word = cap_wdata;
        end
`ifdef DM_MISALIGN_CHECK_EN
        reject = !cap_bac && (lane != 2'd0);
`else
        reject = 1'b0;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cap_we_n    = cap_we;
        cap_bac_n   = cap_bac;
        cap_addr_n  = cap_addr;
        cap_wdata_n = cap_wdata;
        rdata_n     = rdata;
        misalign_n  = 1'b0;
        wr_en       = 1'b0;

        unique case (state)
            IDLE: begin
                if (req) begin
                    cap_we_n    = we;
                    cap_bac_n   = bac_op;
                    cap_addr_n  = addr[BADDR_W-1:0];
                    cap_wdata_n = wdata;
                    cnt_n       = CNT_W'(WAIT_CYCLES);
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = CNT_W'(cnt - CNT_W'(1));
                end else begin
                    state_n    = RESP;
                    misalign_n = reject;
                    if (!reject) begin
                        if (cap_we) begin
                            wr_en = 1'b1;
                        end else if (cap_bac) begin
                            rdata_n = {{24{rd_byte[7]}}, rd_byte};
                        end else begin
                            rdata_n = rd_word;
                        end
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == RESP);
        busy_n  = (state_n != IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request capture, counter, outputs and memory; reset also clears every word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_bac   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            misalign  <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
        end else begin
            cnt       <= cnt_n;
            cap_we    <= cap_we_n;
            cap_bac   <= cap_bac_n;
            cap_addr  <= cap_addr_n;
            cap_wdata <= cap_wdata_n;
            rdata     <= rdata_n;
            ready     <= ready_n;
            misalign  <= misalign_n;
            busy      <= busy_n;
            if (wr_en) begin
                mem[idx] <= wr_word;
            end
        end
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the multi-cycle CPU: the memory-side endpoint of the controller's memory-access stage. It accepts a request (write enable, byte/word access op, address, write data) and services it after a fixed number of wait states. For reads it returns a word or a sign-extended byte. It then signals completion with a one-cycle `ready` pulse, so the controller can leave its memory state.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. The memory holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: wait states between acceptance and access. Legal range 0–15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  1  request valid. Sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read.
- `bac_op`  in  1  0 = word access, 1 = byte access.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data. Byte writes use `wdata[7:0]`.
- `rdata`  out  32  read result. Held until the next completed read.
- `ready`  out  1  one-cycle completion pulse.
- `misalign`  out  1  valid with `ready`: the word access was rejected.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, RESP. All state elements are in one asynchronous-reset register set.
- IDLE:
  - On a clock edge with `req`=1, capture `we`, `bac_op`, `addr`, `wdata`.
  - Load `cnt` with `WAIT_CYCLES` and go to WAIT.
- WAIT:
  - On an edge with `cnt`≠0, decrement `cnt`.
  - On an edge with `cnt`=0, perform the access and go to RESP.
- RESP: `ready`=1. The next edge returns to IDLE unconditionally. `req` is ignored in WAIT and RESP.
- Word index is `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2).
- Byte lane is little-endian: `addr[1:0]`=0 selects bits [7:0], and 3 selects bits [31:24].
- Word read: `rdata` ← mem[index].
- Byte read: `rdata` ← sign-extended selected byte.
- Word write: mem[index] ← `wdata`.
- Byte write: only the selected lane ← `wdata[7:0]`. The other lanes are unchanged.
- Writes leave `rdata` unchanged.
- Captured request fields are frozen from acceptance to completion. Input changes after acceptance have no effect.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `rdata` 0x00000000, `ready` 0, `misalign` 0, `busy` 0.
  - All memory words 0.
- Latency: a request is accepted at edge E0 and the access happens at edge E0+WAIT_CYCLES+1. `ready` is high for exactly the following cycle.
- With `WAIT_CYCLES`=0, `ready` is high in the cycle after E1.
- Throughput: at most one request per WAIT_CYCLES+3 cycles. A `req` held high through RESP is accepted again at the first edge in IDLE.
- `busy` rises in the cycle after acceptance and falls together with `ready`.
- `misalign` is registered with `ready` and is 0 in all other cycles.
- Reset asserted mid-operation:
  - The in-flight access is abandoned and no memory write occurs.
  - All outputs return to their reset values immediately.
  - Memory is cleared.

## Configuration
- `DM_MISALIGN_CHECK_EN` defined:
  - A word access with `addr[1:0]`≠0 performs no write and leaves `rdata` unchanged.
  - It still completes with normal latency, with `ready`=1 and `misalign`=1.
- Macro undefined:
  - `addr[1:0]` is ignored for word accesses (forced alignment).
  - `misalign` is tied to 0.
- Byte accesses are never flagged in either configuration.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10, then word read 0x10:
  - `rdata`=0xDEADBEEF.
  - With `WAIT_CYCLES`=2, `ready` is high exactly in the cycle after the 3rd edge following acceptance.
- Byte write 0x80 to 0x13 over word 0x11223344, then word read → 0x80223344. Byte read at 0x13 → 0xFFFFFF80; byte read at 0x12 → 0x00000022.
- `req` toggled and `addr`/`wdata` changed during WAIT:
  - No second access occurs.
  - Only the captured request is performed.
  - `busy` stays 1 until `ready` falls.
- Word write to 0x22:
  - With the macro, `misalign`=1 and the memory word at 0x20 is unchanged.
  - Without the macro, the word at 0x20 is written.
- `reset` pulsed while in WAIT during a write: memory reads back 0, and `ready`/`busy` are 0 immediately.
- Address 0x00001010 with `ADDR_WIDTH`=10 aliases 0x10: a write to one is visible on a read of the other.
